// File: rtl/ga23_tile_fetch.sv
// ga23_tile_fetch -- per-layer tile-row fetch stage of the GA23 video path.
//
// Accepts tile commands from the layer scanner, issues one 32-bit tile ROM
// read per command on an arbiter port, buffers returned rows in a small FIFO
// and streams them out as 4bpp pixels, one per cycle.
//
// Parameters:
//   DEPTH   - buffered tile rows including the one in flight (1..4)
//   TIMEOUT - watchdog limit in clk cycles (GA23_FETCH_TIMEOUT_EN only)
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   cmd_*             tile command handshake (code, row, flips, palette)
//   rom_addr/rom_req  byte address and single-cycle request to the arbiter
//   rom_data/rom_rdy  returned row data and its single-cycle valid pulse
//   pix_*             pixel stream (valid/ready, colour, palette, last)
//   err               sticky watchdog timeout flag
//
// Optional feature: define GA23_FETCH_TIMEOUT_EN to enable the WAIT watchdog,
// which substitutes a transparent row when the ROM never answers.
module ga23_tile_fetch #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [16:0] cmd_code,
   input  logic [2:0]  cmd_row,
   input  logic        cmd_hflip,
   input  logic        cmd_vflip,
   input  logic [6:0]  cmd_palette,
   output logic [21:0] rom_addr,
   output logic        rom_req,
   input  logic [31:0] rom_data,
   input  logic        rom_rdy,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [3:0]  pix_color,
   output logic [6:0]  pix_palette,
   output logic        pix_last,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
   localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);

   state_t      state, state_nx;
   logic [39:0] mem [0:3];          // {hflip, palette, row data}
   logic [1:0]  wr_ptr, rd_ptr;
   logic [2:0]  count;
   logic [2:0]  pix_idx;
   logic        hflip_q;
   logic [6:0]  pal_q;
   logic [21:0] addr_q;

   logic        accept, push, pop, to_fire;
   logic [31:0] push_data;
   logic [39:0] head;
   logic [2:0]  nib_sel;

   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      rom_req   = 1'b0;
      push      = 1'b0;
      push_data = rom_data;
      case (state)
         IDLE: begin
            cmd_ready = !reset && (count < DEPTH_C);
            if (cmd_valid && cmd_ready) state_nx = REQ;
         end
         REQ: begin
            rom_req  = 1'b1;
            state_nx = WAIT;
         end
         WAIT: begin
            if (rom_rdy) begin
               push     = 1'b1;
               state_nx = IDLE;
            end else if (to_fire) begin
               push      = 1'b1;
               push_data = '0;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign accept   = cmd_valid && cmd_ready;
   assign pix_valid = (count != 3'd0);
   assign pop      = pix_valid && pix_ready && (pix_idx == 3'd7);
   assign rom_addr = addr_q;

   // Unflipped rows start at the top nibble, so invert the index to count down.
   assign head        = mem[rd_ptr];
   assign nib_sel     = head[39] ? pix_idx : ~pix_idx;
   assign pix_color   = pix_valid ? head[{nib_sel, 2'b00} +: 4] : 4'd0;
   assign pix_palette = pix_valid ? head[38:32] : 7'd0;
   assign pix_last    = pix_valid && (pix_idx == 3'd7);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         pix_idx <= '0;
         hflip_q <= 1'b0;
         pal_q   <= '0;
         addr_q  <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            addr_q  <= {cmd_code, cmd_row ^ {3{cmd_vflip}}, 2'b00};
            hflip_q <= cmd_hflip;
            pal_q   <= cmd_palette;
         end
         if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? 2'd0 : wr_ptr + 2'd1;
         if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? 2'd0 : rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
         // 3-bit index wraps from 7 to 0 together with the pop.
         if (pix_valid && pix_ready) pix_idx <= pix_idx + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {hflip_q, pal_q, push_data};
   end

`ifdef GA23_FETCH_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] wait_cnt;

   // Counter holds k during the (k+1)th WAIT cycle; fires on the TIMEOUT-th.
   always_ff @(posedge clk) begin
      if (reset)              wait_cnt <= '0;
      else if (state == REQ)  wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
   end

   assign to_fire = (state == WAIT) && (wait_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (reset)                     err <= 1'b0;
      else if (to_fire && !rom_rdy)  err <= 1'b1;
   end
`else
   assign to_fire = 1'b0;
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_ga23_tile_fetch.sv
// Testbench for ga23_tile_fetch: directed commands with hand-computed ROM
// addresses and pixel sequences, checked by a scoreboard monitor.
module tb_ga23_tile_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [16:0] cmd_code = '0;
   logic [2:0]  cmd_row = '0;
   logic        cmd_hflip = 1'b0;
   logic        cmd_vflip = 1'b0;
   logic [6:0]  cmd_palette = '0;
   logic [21:0] rom_addr;
   logic        rom_req;
   logic [31:0] rom_data = '0;
   logic        rom_rdy = 1'b0;
   logic        pix_valid;
   logic        pix_ready = 1'b0;
   logic [3:0]  pix_color;
   logic [6:0]  pix_palette;
   logic        pix_last;
   logic        err;

   always #5 clk = ~clk;

   ga23_tile_fetch #(.DEPTH(2), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
      .cmd_row(cmd_row), .cmd_hflip(cmd_hflip), .cmd_vflip(cmd_vflip),
      .cmd_palette(cmd_palette),
      .rom_addr(rom_addr), .rom_req(rom_req), .rom_data(rom_data), .rom_rdy(rom_rdy),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_color(pix_color),
      .pix_palette(pix_palette), .pix_last(pix_last), .err(err)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   logic [11:0] exp_pix[$];    // {colour, palette, last}
   logic [21:0] exp_addr[$];

   task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic fail(input string name, input string what);
      n_total++;
      $display("FAIL %s: got %s expected an in-bound DUT event", name, what);
   endtask

   // Expected colours: hflip=0 reads nibbles from the top, hflip=1 from the bottom.
   task automatic push_row(input logic [31:0] d, input logic h, input logic [6:0] p);
      for (int i = 0; i < 8; i++) begin
         int sh;
         logic [3:0] c;
         sh = h ? 4 * i : 28 - 4 * i;
         c  = 4'(d >> sh);
         exp_pix.push_back({c, p, i == 7});
      end
   endtask

   // Monitor: pixel scoreboard, hold stability, request pulse and address.
   logic        hold_v = 1'b0;
   logic [11:0] hold_val = '0;
   logic        prev_req = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (hold_v)
            chk("pixel_hold", {pix_valid, pix_color, pix_palette, pix_last}, {1'b1, hold_val});
         if (pix_valid && pix_ready) begin
            if (exp_pix.size() == 0) fail("pixel_unexpected", "extra pixel");
            else chk("pixel", {pix_color, pix_palette, pix_last}, exp_pix.pop_front());
         end
         hold_v   = pix_valid && !pix_ready;
         hold_val = {pix_color, pix_palette, pix_last};
         if (rom_req) begin
            if (prev_req) fail("rom_req_double", "request high two cycles");
            if (exp_addr.size() == 0) fail("rom_req_unexpected", "extra request");
            else chk("rom_addr", rom_addr, exp_addr.pop_front());
         end
      end else begin
         hold_v = 1'b0;
      end
      prev_req = rom_req;
   end

   task automatic send_cmd(input logic [16:0] code, input logic [2:0] row, input logic h,
                           input logic v, input logic [6:0] pal, input logic [21:0] addr);
      bit ok = 0;
      cmd_code = code; cmd_row = row; cmd_hflip = h; cmd_vflip = v; cmd_palette = pal;
      cmd_valid = 1'b1;
      exp_addr.push_back(addr);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      if (!ok) fail("cmd_accept", "timeout");
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_req();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rom_req) begin ok = 1; break; end
      end
      if (!ok) fail("rom_req_wait", "timeout");
   endtask

   task automatic answer(input logic [31:0] d, input logic h, input logic [6:0] p);
      push_row(d, h, p);
      @(posedge clk); #1;
      rom_rdy = 1'b1; rom_data = d;
      @(posedge clk); #1;
      rom_rdy = 1'b0; rom_data = '0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_pix.size() == 0 && !pix_valid) begin ok = 1; break; end
      end
      if (!ok) fail("drain", "timeout");
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {cmd_ready, rom_req, pix_valid, pix_last, err, pix_color, pix_palette},
          '0);
      chk("rst_addr", rom_addr, 22'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", cmd_ready, 1'b1);
      @(posedge clk); #1;

      // Basic fetch, address = code<<5 | row<<2
      pix_ready = 1'b1;
      send_cmd(17'h00123, 3'd5, 1'b0, 1'b0, 7'h2A, 22'h002474);
      wait_req();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("single_req", {rom_req, cmd_ready}, 2'b00);
      end
      answer(32'h12345678, 1'b0, 7'h2A);
      drain();

      // vflip maps row 5 to 2, hflip reverses pixels
      send_cmd(17'h00123, 3'd5, 1'b1, 1'b1, 7'h55, 22'h002468);
      wait_req();
      answer(32'h12345678, 1'b1, 7'h55);
      drain();

      // FIFO full with DEPTH=2 and backpressure
      pix_ready = 1'b0;
      send_cmd(17'h00001, 3'd0, 1'b0, 1'b0, 7'h01, 22'h000020);
      wait_req();
      answer(32'hFEDCBA98, 1'b0, 7'h01);
      send_cmd(17'h1FFFF, 3'd7, 1'b1, 1'b0, 7'h7F, 22'h3FFFFC);
      wait_req();
      answer(32'h0F1E2D3C, 1'b1, 7'h7F);
      cmd_code = 17'h0ABCD; cmd_row = 3'd3; cmd_hflip = 1'b0; cmd_vflip = 1'b1;
      cmd_palette = 7'h33; cmd_valid = 1'b1;
      exp_addr.push_back(22'h1579B0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("full_not_ready", {cmd_ready, pix_valid}, 2'b01);
      end
      @(posedge clk); #1;
      pix_ready = 1'b1;
      begin
         bit ok = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_valid && pix_last) begin ok = 1; break; end
         end
         if (!ok) fail("first_row_last", "timeout");
      end
      chk("ready_during_pop", cmd_ready, 1'b0);
      @(negedge clk);
      chk("ready_after_pop", {cmd_ready, pix_valid}, 2'b11);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_req();
      answer(32'h89ABCDEF, 1'b0, 7'h33);
      drain();

      // rom_rdy in the same cycle as the last-pixel pop
      pix_ready = 1'b0;
      send_cmd(17'h00010, 3'd1, 1'b0, 1'b0, 7'h11, 22'h000204);
      wait_req();
      answer(32'h0123ABCD, 1'b0, 7'h11);
      send_cmd(17'h00020, 3'd6, 1'b1, 1'b0, 7'h22, 22'h000418);
      wait_req();
      @(posedge clk); #1;
      pix_ready = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      push_row(32'hCAFE0123, 1'b1, 7'h22);
      rom_rdy = 1'b1; rom_data = 32'hCAFE0123;
      @(negedge clk);
      chk("coincide", {pix_last, pix_valid, rom_rdy, pix_ready}, 4'hF);
      @(posedge clk); #1;
      rom_rdy = 1'b0; rom_data = '0;
      @(negedge clk);
      chk("count_kept", {pix_valid, cmd_ready}, 2'b11);
      drain();

      // pix_ready toggling while two rows arrive
      pix_ready = 1'b0;
      fork
         for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            pix_ready = ~pix_ready;
         end
      join_none
      send_cmd(17'h00100, 3'd0, 1'b0, 1'b0, 7'h05, 22'h002000);
      wait_req();
      answer(32'h13579BDF, 1'b0, 7'h05);
      send_cmd(17'h00101, 3'd7, 1'b1, 1'b1, 7'h06, 22'h002020);
      wait_req();
      answer(32'h2468ACE0, 1'b1, 7'h06);
      wait fork;
      pix_ready = 1'b1;
      drain();

      // Reset while waiting, then a late response
      send_cmd(17'h00555, 3'd2, 1'b0, 1'b0, 7'h44, 22'h00AAA8);
      wait_req();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      rom_rdy = 1'b1; rom_data = 32'hFFFFFFFF;
      @(posedge clk); #1;
      rom_rdy = 1'b0; rom_data = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("late_rdy_ignored", {pix_valid, cmd_ready, rom_req}, 3'b010);
      end
      chk("addr_after_rst", rom_addr, 22'h0);

`ifdef GA23_FETCH_TIMEOUT_EN
      // Watchdog: 16 WAIT cycles, then a transparent row and sticky err
      @(posedge clk); #1;
      push_row(32'h0, 1'b1, 7'h3C);
      send_cmd(17'h00777, 3'd3, 1'b1, 1'b0, 7'h3C, 22'h00EEEC);
      wait_req();
      begin
         int n = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (err) break;
         end
         chk("timeout_cycles", 40'(n), 40'd17);
      end
      @(posedge clk); #1;
      rom_rdy = 1'b1; rom_data = 32'hFFFFFFFF;
      @(posedge clk); #1;
      rom_rdy = 1'b0; rom_data = '0;
      drain();
      chk("err_sticky", {err, pix_valid}, 2'b10);
`else
      @(negedge clk);
      chk("err_tied", err, 1'b0);
`endif

      chk("pix_scoreboard_empty", 40'(exp_pix.size()), 40'd0);
      chk("addr_scoreboard_empty", 40'(exp_addr.size()), 40'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
